// File: rtl/hex_multi_control.sv
`default_nettype none
// ============================================================================
// Module   : hex_multi_control
// Brief    : Avalon-mapped multi-digit 7-segment controller with optional
//            per-digit blink, enabled by the HEX_BLINK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module hex_multi_control #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iChip_select_n,
  input  logic                    iWrite_n,
  input  logic                    iRead_n,
  input  logic [3:0]              iAddress,
  input  logic [7:0]              iWritedata,
  output logic [7:0]              oReaddata,
  output logic [7*NUM_DIGITS-1:0] oHex_Display
);

  localparam logic [3:0] c_ADDR_CTRL  = 4'd8;
  localparam logic [3:0] c_ADDR_BLINK = 4'd9;
  localparam logic [4:0] c_DIGIT_RST  = 5'h10;
  localparam logic [1:0] c_CTRL_RST   = 2'b01;

  logic [4:0]              r_digit [NUM_DIGITS];
  logic [1:0]              r_ctrl;
  logic                    w_wrEn;
  logic                    w_rdEn;
  logic [7:0]              w_rdData;
  logic [7:0]              w_blinkRd;
  logic [NUM_DIGITS-1:0]   w_blinkOff;
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic                    w_zeroRun;
  logic [7*NUM_DIGITS-1:0] w_hexNext;
  logic                    w_unused;

  assign w_wrEn   = ~iChip_select_n & ~iWrite_n;
  assign w_rdEn   = ~iChip_select_n & ~iRead_n;
  assign w_unused = &{1'b0, iWritedata};

  function automatic logic [6:0] segDecode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

`ifdef HEX_BLINK_EN
  localparam int                   c_CNT_W   = $clog2(BLINK_DIV);
  localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(BLINK_DIV - 1);

  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_blink;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_blink <= '0;
    end else begin
      if (r_cnt == c_CNT_MAX) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_wrEn && iAddress == c_ADDR_BLINK)
        r_blink <= iWritedata[NUM_DIGITS-1:0];
    end
  end

  assign w_blinkOff = r_blink & {NUM_DIGITS{r_phase}};
  assign w_blinkRd  = 8'(r_blink);
`else
  assign w_blinkOff = '0;
  assign w_blinkRd  = 8'h00;
`endif

  // Register reads are taken before this cycle's write lands, so a
  // simultaneous read/write of one address returns the old contents.
  always_comb begin
    w_rdData = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (iAddress == 4'(k))
        w_rdData = {3'b000, r_digit[k]};
    if (iAddress == c_ADDR_CTRL)
      w_rdData = {6'b000000, r_ctrl};
    if (iAddress == c_ADDR_BLINK)
      w_rdData = w_blinkRd;
  end

  always_comb begin
    w_lzBlank = '0;
    w_zeroRun = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zeroRun    = w_zeroRun & (r_digit[k][3:0] == 4'd0);
      w_lzBlank[k] = r_ctrl[1] & w_zeroRun;
    end
    w_hexNext = '1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (!(r_digit[k][4] | ~r_ctrl[0] | w_lzBlank[k] | w_blinkOff[k]))
        w_hexNext[7*k +: 7] = segDecode(r_digit[k][3:0]);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        r_digit[k] <= c_DIGIT_RST;
      r_ctrl       <= c_CTRL_RST;
      oReaddata    <= 8'h00;
      oHex_Display <= '1;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (w_wrEn && iAddress == 4'(k))
          r_digit[k] <= iWritedata[4:0];
      if (w_wrEn && iAddress == c_ADDR_CTRL)
        r_ctrl <= iWritedata[1:0];
      if (w_rdEn)
        oReaddata <= w_rdData;
      oHex_Display <= w_hexNext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_multi_control.sv
`default_nettype none
// Testbench for hex_multi_control: bus read scoreboard plus a reference
// display model; blink checks follow HEX_BLINK_EN.
module tb_hex_multi_control;

  localparam int c_ND  = 6;
  localparam int c_DIV = 4;
  localparam int c_HW  = 7 * c_ND;

  logic            iClk = 1'b0;
  logic            iReset;
  logic            iChip_select_n;
  logic            iWrite_n;
  logic            iRead_n;
  logic [3:0]      iAddress;
  logic [7:0]      iWritedata;
  logic [7:0]      oReaddata;
  logic [c_HW-1:0] oHex_Display;

  int         errCount   = 0;
  int         checkCount = 0;
  logic [7:0] expQ[$];
  logic [4:0] mDigit[c_ND];
  logic [1:0] mCtrl;
  logic [c_ND-1:0] mBlink;

  always #5 iClk = ~iClk;

  hex_multi_control #(
    .NUM_DIGITS (c_ND),
    .BLINK_DIV  (c_DIV)
  ) dut (
    .iClk           (iClk),
    .iReset         (iReset),
    .iChip_select_n (iChip_select_n),
    .iWrite_n       (iWrite_n),
    .iRead_n        (iRead_n),
    .iAddress       (iAddress),
    .iWritedata     (iWritedata),
    .oReaddata      (oReaddata),
    .oHex_Display   (oHex_Display)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] segRef(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected display with blink phase 0.
  function automatic logic [c_HW-1:0] modelHex();
    logic [c_HW-1:0] h;
    bit allZero;
    bit lz;
    h = '1;
    allZero = 1'b1;
    for (int k = c_ND - 1; k >= 0; k--) begin
      allZero = allZero && (mDigit[k][3:0] == 4'd0);
      lz = (k > 0) && mCtrl[1] && allZero;
      if (!mDigit[k][4] && mCtrl[0] && !lz)
        h[7*k +: 7] = segRef(mDigit[k][3:0]);
    end
    return h;
  endfunction

  function automatic logic [7:0] modelRead(input logic [3:0] a);
    if (a < 4'(c_ND)) return {3'b000, mDigit[a]};
    if (a == 4'd8) return {6'b000000, mCtrl};
`ifdef HEX_BLINK_EN
    if (a == 4'd9) return 8'(mBlink);
`endif
    return 8'h00;
  endfunction

  task automatic modelWrite(input logic [3:0] a, input logic [7:0] d);
    if (a < 4'(c_ND)) mDigit[a] = d[4:0];
    if (a == 4'd8) mCtrl = d[1:0];
`ifdef HEX_BLINK_EN
    if (a == 4'd9) mBlink = d[c_ND-1:0];
`endif
  endtask

  task automatic modelReset();
    for (int k = 0; k < c_ND; k++) mDigit[k] = 5'h10;
    mCtrl  = 2'b01;
    mBlink = '0;
    expQ.delete();
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idleBus();
    iChip_select_n = 1'b1;
    iWrite_n       = 1'b1;
    iRead_n        = 1'b1;
  endtask

  task automatic doReset();
    idleBus();
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    modelReset();
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
    iChip_select_n = 1'b0; iWrite_n = 1'b0; iRead_n = 1'b1;
    iAddress = a; iWritedata = d;
    tick();
    idleBus();
    modelWrite(a, d);
  endtask

  task automatic busRead(input logic [3:0] a, input string tag);
    logic [7:0] e;
    iChip_select_n = 1'b0; iWrite_n = 1'b1; iRead_n = 1'b0;
    iAddress = a;
    expQ.push_back(modelRead(a));
    tick();
    idleBus();
    e = expQ.pop_front();
    checkValue(tag, oReaddata, e);
  endtask

  task automatic busReadWrite(input logic [3:0] a, input logic [7:0] d, input string tag);
    logic [7:0] e;
    iChip_select_n = 1'b0; iWrite_n = 1'b0; iRead_n = 1'b0;
    iAddress = a; iWritedata = d;
    expQ.push_back(modelRead(a));
    tick();
    idleBus();
    modelWrite(a, d);
    e = expQ.pop_front();
    checkValue(tag, oReaddata, e);
  endtask

  // Must start right after a single reset edge R: the three writes land on
  // edges R+1..R+3 and each later tick t corresponds to edge R+t.
  task automatic blinkSequence(input int tLast);
    logic [6:0] d0Exp;
    busWrite(4'd0, 8'h08);
    busWrite(4'd1, 8'h03);
    busWrite(4'd9, 8'h01);
    for (int t = 4; t <= tLast; t++) begin
      tick();
`ifdef HEX_BLINK_EN
      d0Exp = ((((t - 1) / c_DIV) % 2) == 1) ? 7'h7F : 7'b0000000;
`else
      d0Exp = 7'b0000000;
`endif
      checkValue($sformatf("blink_t%0d", t), oHex_Display[13:0], {7'b0110000, d0Exp});
    end
  endtask

  initial begin
    logic [c_HW-1:0] lzExp;
    iReset = 1'b1; iAddress = 4'd0; iWritedata = 8'h00;
    idleBus();
    tick();
    doReset();

    checkValue("rst_hex", oHex_Display, {c_HW{1'b1}});
    checkValue("rst_rdata", oReaddata, 8'h00);
    busRead(4'd0, "rst_rd_d0");
    busRead(4'd8, "rst_rd_ctrl");
    busRead(4'd9, "rst_rd_blink");

    busWrite(4'd2, 8'h0A);
    checkValue("hex_latency_1cyc", oHex_Display, {c_HW{1'b1}});
    tick();
    checkValue("d2_A", oHex_Display[20:14], 7'b0001000);
    checkValue("hex_model_A", oHex_Display, modelHex());
    busRead(4'd2, "rd_d2");
    tick();
    checkValue("rd_hold", oReaddata, 8'h0A);
    busWrite(4'd3, 8'hE7);
    busRead(4'd3, "rd_unused_bits");

    for (int k = 0; k < c_ND; k++) busWrite(4'(k), (k == 2) ? 8'h05 : 8'h00);
    busWrite(4'd8, 8'h03);
    tick();
    lzExp = {7'h7F, 7'h7F, 7'h7F, 7'b0010010, 7'b1000000, 7'b1000000};
    checkValue("lz_blank", oHex_Display, lzExp);
    checkValue("lz_model", oHex_Display, modelHex());
    busWrite(4'd8, 8'h01);
    tick();
    checkValue("lz_off", oHex_Display, modelHex());
    busWrite(4'd8, 8'h00);
    tick();
    checkValue("disable", oHex_Display, {c_HW{1'b1}});
    busWrite(4'd8, 8'hFD);
    busRead(4'd8, "rd_ctrl_mask");

    for (int v = 0; v < 16; v++) begin
      busWrite(4'd0, 8'(v));
      tick();
      checkValue($sformatf("dec_%0h", v), oHex_Display[6:0], segRef(4'(v)));
    end
    busWrite(4'd0, 8'h18);
    tick();
    checkValue("blank_bit", oHex_Display[6:0], 7'h7F);

    busWrite(4'hF, 8'h1F);
    busReadWrite(4'd1, 8'h09, "rw_old");
    busRead(4'd1, "rw_new");
    for (int a = 0; a < 16; a++) busRead(4'(a), $sformatf("regmap_%0d", a));
    tick();
    checkValue("regmap_hex", oHex_Display, modelHex());

`ifdef HEX_BLINK_EN
    busWrite(4'd9, 8'hFF);
    busRead(4'd9, "rd_blink_mask");
    doReset();
    blinkSequence(16);
    repeat (4) tick();
    iReset = 1'b1;
    iChip_select_n = 1'b0; iWrite_n = 1'b0; iRead_n = 1'b0;
    iAddress = 4'd0; iWritedata = 8'h05;
    tick();
    idleBus();
    iReset = 1'b0;
    modelReset();
    checkValue("rst_in_phase1_hex", oHex_Display, {c_HW{1'b1}});
    checkValue("rst_in_phase1_rdata", oReaddata, 8'h00);
    blinkSequence(9);
    busRead(4'd0, "post_rst_d0");
    busRead(4'd9, "post_rst_blink");
`else
    busWrite(4'd9, 8'hFF);
    busRead(4'd9, "rd_blink_absent");
    doReset();
    blinkSequence(16);
    iReset = 1'b1;
    iChip_select_n = 1'b0; iWrite_n = 1'b0; iRead_n = 1'b0;
    iAddress = 4'd0; iWritedata = 8'h05;
    tick();
    idleBus();
    iReset = 1'b0;
    modelReset();
    checkValue("rst_prio_hex", oHex_Display, {c_HW{1'b1}});
    checkValue("rst_prio_rdata", oReaddata, 8'h00);
    busRead(4'd0, "post_rst_d0");
`endif
    busRead(4'd8, "post_rst_ctrl");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire
